// File: rtl/urv_dm_ahb_bridge.sv
// uRV data-memory port to single AHB-Lite master transfers.
// Handles one CPU request at a time, with wait states, error responses, illegal lane masks and a data-phase watchdog.
module urv_dm_ahb_bridge #(
  parameter logic [3:0]  HPROT_VAL      = 4'b0011,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_store_i,
  input  logic        dm_load_i,
  output logic [31:0] dm_data_l_o,
  output logic        dm_load_done_o,
  output logic        dm_store_done_o,
  output logic        dm_ready_o,
  output logic        bus_err_o,
  output logic [31:0] HADDR_O,
  output logic [1:0]  HTRANS_O,
  output logic [2:0]  HSIZE_O,
  output logic        HWRITE_O,
  output logic [31:0] HWDATA_O,
  output logic [2:0]  HBURST_O,
  output logic [3:0]  HPROT_O,
  output logic        HMASTLOCK_O,
  input  logic [31:0] HRDATA_I,
  input  logic        HREADY_I,
  input  logic        HRESP_I
);
  // state | meaning
  // IDLE  | ready, waiting for a CPU load/store request
  // ADDR  | address phase (NONSEQ); for an illegal store mask, a bus-idle holding cycle
  // DATA  | data phase, waiting on HREADY_I with the watchdog running
  // DONE  | one-cycle done pulse (plus bus_err_o on failure) to the CPU
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

  localparam logic             WDOG_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] WDOG_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_haddr;
  logic [2:0]       r_hsize;
  logic             r_hwrite;
  logic [31:0]      r_hwdata;
  logic             r_illegal;
  logic             r_err;
  logic [31:0]      r_ldata;
  logic [CNT_W-1:0] r_wdog;

  logic             w_req;
  logic             w_legal;
  logic [1:0]       w_off;
  logic [2:0]       w_size;
  logic             w_wdog_hit;
  logic             w_unused;

  // The word address comes from the CPU; the low bits are rebuilt from the lane mask.
  assign w_unused   = ^dm_addr_i[1:0];
  assign w_req      = dm_load_i | dm_store_i;
  assign w_wdog_hit = WDOG_EN && (r_wdog == WDOG_LAST);

  always_comb begin
    w_legal = 1'b1;
    w_off   = 2'b00;
    w_size  = 3'b010;
    case (dm_data_select_i)
      4'b0001: begin w_off = 2'd0; w_size = 3'b000; end
      4'b0010: begin w_off = 2'd1; w_size = 3'b000; end
      4'b0100: begin w_off = 2'd2; w_size = 3'b000; end
      4'b1000: begin w_off = 2'd3; w_size = 3'b000; end
      4'b0011: begin w_off = 2'd0; w_size = 3'b001; end
      4'b1100: begin w_off = 2'd2; w_size = 3'b001; end
      4'b1111: begin w_off = 2'd0; w_size = 3'b010; end
      default: w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_req) w_next = S_ADDR;
      S_ADDR: begin
        if (r_illegal)     w_next = S_DONE;
        else if (HREADY_I) w_next = S_DATA;
      end
      S_DATA: if (HREADY_I || w_wdog_hit) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_haddr   <= '0;
      r_hsize   <= 3'b010;
      r_hwrite  <= 1'b0;
      r_hwdata  <= '0;
      r_illegal <= 1'b0;
      r_err     <= 1'b0;
      r_ldata   <= '0;
      r_wdog    <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            // Store wins when both strobes are high; loads are always a full word.
            r_hwrite  <= dm_store_i;
            r_illegal <= dm_store_i & ~w_legal;
            r_err     <= dm_store_i & ~w_legal;
            r_wdog    <= '0;
            r_haddr   <= {dm_addr_i[31:2], dm_store_i ? w_off : 2'b00};
            r_hsize   <= dm_store_i ? w_size : 3'b010;
            if (dm_store_i) r_hwdata <= dm_data_s_i;
          end
        end
        S_DATA: begin
          if (HREADY_I) begin
            r_err <= HRESP_I;
            if (!r_hwrite && !HRESP_I) r_ldata <= HRDATA_I;
          end else if (w_wdog_hit) begin
            r_err <= 1'b1;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign HTRANS_O        = (r_state == S_ADDR && !r_illegal) ? 2'b10 : 2'b00;
  assign HADDR_O         = r_haddr;
  assign HSIZE_O         = r_hsize;
  assign HWRITE_O        = r_hwrite;
  assign HWDATA_O        = r_hwdata;
  assign HBURST_O        = 3'b000;
  assign HPROT_O         = HPROT_VAL;
  assign HMASTLOCK_O     = 1'b0;
  assign dm_ready_o      = (r_state == S_IDLE);
  assign dm_load_done_o  = (r_state == S_DONE) && !r_hwrite;
  assign dm_store_done_o = (r_state == S_DONE) && r_hwrite;
  assign bus_err_o       = (r_state == S_DONE) && r_err;
  assign dm_data_l_o     = r_ldata;

endmodule

// File: tb/tb_urv_dm_ahb_bridge.sv
// Bench for urv_dm_ahb_bridge: directed scenarios plus randomized transfers against a transaction-level model.
module tb_urv_dm_ahb_bridge;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] dm_addr_i, dm_data_s_i, dm_data_l_o;
  logic [3:0]  dm_data_select_i;
  logic        dm_store_i, dm_load_i;
  logic        dm_load_done_o, dm_store_done_o, dm_ready_o, bus_err_o;
  logic [31:0] HADDR_O, HWDATA_O, HRDATA_I;
  logic [1:0]  HTRANS_O;
  logic [2:0]  HSIZE_O, HBURST_O;
  logic        HWRITE_O, HMASTLOCK_O, HREADY_I, HRESP_I;
  logic [3:0]  HPROT_O;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model_ldata = '0;

  typedef struct packed {
    logic        st;
    logic        ld;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  mask;
    int          a;
    int          d;
    logic        err;
  } xfer_t;

  typedef struct packed {
    int          done_cyc;
    int          nseq;
    int          unstable;
    int          busy_ready;
    logic        ld;
    logic        st;
    logic        err;
    logic        extra;
    logic [31:0] haddr;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [31:0] hwdata;
    logic [31:0] ldata;
  } obs_t;

  urv_dm_ahb_bridge #(.HPROT_VAL(4'b0011), .TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .dm_addr_i(dm_addr_i), .dm_data_s_i(dm_data_s_i), .dm_data_select_i(dm_data_select_i),
    .dm_store_i(dm_store_i), .dm_load_i(dm_load_i), .dm_data_l_o(dm_data_l_o),
    .dm_load_done_o(dm_load_done_o), .dm_store_done_o(dm_store_done_o),
    .dm_ready_o(dm_ready_o), .bus_err_o(bus_err_o),
    .HADDR_O(HADDR_O), .HTRANS_O(HTRANS_O), .HSIZE_O(HSIZE_O), .HWRITE_O(HWRITE_O),
    .HWDATA_O(HWDATA_O), .HBURST_O(HBURST_O), .HPROT_O(HPROT_O), .HMASTLOCK_O(HMASTLOCK_O),
    .HRDATA_I(HRDATA_I), .HREADY_I(HREADY_I), .HRESP_I(HRESP_I)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish within 500000 time units");
    $fatal(1, "time limit");
  end

  function automatic string fmt(input obs_t o);
    return $sformatf("done@%0d ld=%b st=%b err=%b extra=%b nseq=%0d unst=%0d rdy=%0d haddr=%h hsize=%b hwrite=%b hwdata=%h ldata=%h",
                     o.done_cyc, o.ld, o.st, o.err, o.extra, o.nseq, o.unstable, o.busy_ready,
                     o.haddr, o.hsize, o.hwrite, o.hwdata, o.ldata);
  endfunction

  // Transaction-level expectation from the lane/latency rules.
  function automatic obs_t model(input xfer_t x, input logic [31:0] prev);
    obs_t e;
    int   ones, low;
    bit   legal, tmo;
    e     = '0;
    ones  = $countones(x.mask);
    low   = 0;
    for (int b = 3; b >= 0; b--) if (x.mask[b]) low = b;
    legal = !x.st || ones == 1 || ones == 4 || (ones == 2 && (x.mask == 4'b0011 || x.mask == 4'b1100));
    tmo   = legal && (x.d >= TO);
    e.done_cyc = !legal ? 1 : (tmo ? 1 + x.a + TO : 2 + x.a + x.d);
    e.nseq     = legal ? x.a + 1 : 0;
    e.st       = x.st;
    e.ld       = !x.st;
    e.err      = !legal || tmo || x.err;
    if (legal) begin
      e.haddr  = {x.addr[31:2], x.st ? 2'(low) : 2'b00};
      e.hsize  = !x.st ? 3'b010 : (ones == 1 ? 3'b000 : (ones == 2 ? 3'b001 : 3'b010));
      e.hwrite = x.st;
      e.hwdata = x.st ? x.wdata : 32'h0;
    end
    e.ldata = (!x.st && !e.err) ? x.rdata : prev;
    return e;
  endfunction

  // CPU request plus a cycle-scheduled slave; collects what the bridge did.
  task automatic run_xfer(input xfer_t x, output obs_t o);
    bit seen, done;
    int k;
    o = '0;
    o.done_cyc = -1;
    seen = 0;
    done = 0;
    @(negedge clk);
    dm_addr_i = x.addr; dm_data_s_i = x.wdata; dm_data_select_i = x.mask;
    dm_store_i = x.st; dm_load_i = x.ld; HREADY_I = 1'b1; HRESP_I = 1'b0;
    @(posedge clk); #1;
    dm_store_i = 1'b0; dm_load_i = 1'b0;
    for (int j = 0; j < 40 && !done; j++) begin
      if (HTRANS_O == 2'b10) begin
        o.nseq++;
        if (!seen) begin
          seen = 1; o.haddr = HADDR_O; o.hsize = HSIZE_O; o.hwrite = HWRITE_O;
        end else if ({HADDR_O, HSIZE_O, HWRITE_O} !== {o.haddr, o.hsize, o.hwrite}) o.unstable++;
      end
      if (j == x.a + 1 && seen && x.st) o.hwdata = HWDATA_O;
      if (dm_ready_o) o.busy_ready++;
      if (dm_load_done_o || dm_store_done_o || bus_err_o) begin
        done = 1; o.done_cyc = j;
        o.ld = dm_load_done_o; o.st = dm_store_done_o; o.err = bus_err_o;
      end else begin
        k = j + 1;
        HREADY_I = 1'b1; HRESP_I = 1'b0; HRDATA_I = $urandom;
        if (k <= x.a) HREADY_I = 1'b0;
        else if (k > x.a + 1 && k <= x.a + 1 + x.d) begin
          HREADY_I = 1'b0; HRESP_I = x.err && (k == x.a + 1 + x.d);
        end else if (k == x.a + 2 + x.d) begin
          HRESP_I = x.err; HRDATA_I = x.rdata;
        end
        @(posedge clk); #1;
      end
    end
    HREADY_I = 1'b1; HRESP_I = 1'b0;
    if (done) begin
      @(posedge clk); #1;
      o.extra = dm_load_done_o | dm_store_done_o | bus_err_o | !dm_ready_o;
    end
    o.ldata = dm_data_l_o;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({HTRANS_O, HADDR_O, HSIZE_O, HWRITE_O, HWDATA_O} !== {2'b00, 32'h0, 3'b010, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_bus: got trans=%b addr=%h size=%b wr=%b wd=%h, expected 00/0/010/0/0", HTRANS_O, HADDR_O, HSIZE_O, HWRITE_O, HWDATA_O);
    end
    n_checks++;
    if ({dm_ready_o, dm_load_done_o, dm_store_done_o, bus_err_o, dm_data_l_o} !== {4'b1000, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_cpu: got rdy=%b ld=%b st=%b err=%b ldata=%h, expected 1/0/0/0/0", dm_ready_o, dm_load_done_o, dm_store_done_o, bus_err_o, dm_data_l_o);
    end
    n_checks++;
    if ({HBURST_O, HPROT_O, HMASTLOCK_O} !== {3'b000, 4'b0011, 1'b0}) begin
      n_fail++;
      $display("FAIL constants: got burst=%b prot=%b lock=%b, expected 000/0011/0", HBURST_O, HPROT_O, HMASTLOCK_O);
    end
    @(negedge clk);
    rst_i = 1'b0;
    model_ldata = '0;
  endtask

  task automatic test_word_load();
    xfer_t x; obs_t o, e;
    x = '{st:0, ld:1, addr:32'h0000_0104, wdata:0, rdata:32'hDEADBEEF, mask:4'b0000, a:0, d:0, err:0};
    run_xfer(x, o);
    e = model(x, model_ldata); model_ldata = e.ldata;
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL word_load: got %s | expected %s", fmt(o), fmt(e)); end
    n_checks++;
    if (o.done_cyc + 1 !== 3 || o.ldata !== 32'hDEADBEEF || o.haddr !== 32'h104) begin
      n_fail++; $display("FAIL word_load_latency: got %0d cycles ldata=%h haddr=%h, expected 3 DEADBEEF 104", o.done_cyc + 1, o.ldata, o.haddr);
    end
  endtask

  task automatic test_byte_store();
    xfer_t x; obs_t o, e;
    x = '{st:1, ld:0, addr:32'h200, wdata:32'h00AB0000, rdata:0, mask:4'b0100, a:0, d:0, err:0};
    run_xfer(x, o);
    e = model(x, model_ldata); model_ldata = e.ldata;
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL byte_store: got %s | expected %s", fmt(o), fmt(e)); end
    n_checks++;
    if ({o.haddr, o.hsize, o.hwrite, o.hwdata} !== {32'h202, 3'b000, 1'b1, 32'h00AB0000}) begin
      n_fail++; $display("FAIL byte_store_bus: got addr=%h size=%b wr=%b wd=%h, expected 202/000/1/00AB0000", o.haddr, o.hsize, o.hwrite, o.hwdata);
    end
  endtask

  task automatic test_half_store_waits();
    xfer_t x; obs_t o, e;
    x = '{st:1, ld:0, addr:32'h0000_0300, wdata:32'hBEEF0000, rdata:0, mask:4'b1100, a:2, d:3, err:0};
    run_xfer(x, o);
    e = model(x, model_ldata); model_ldata = e.ldata;
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL half_store_waits: got %s | expected %s", fmt(o), fmt(e)); end
    n_checks++;
    if (o.done_cyc + 1 !== 8 || o.haddr !== 32'h302 || o.hsize !== 3'b001 || o.unstable !== 0) begin
      n_fail++; $display("FAIL half_store_latency: got %0d cycles addr=%h size=%b unstable=%0d, expected 8 302 001 0", o.done_cyc + 1, o.haddr, o.hsize, o.unstable);
    end
  endtask

  task automatic test_load_error();
    xfer_t x; obs_t o, e;
    x = '{st:0, ld:1, addr:32'h0000_0400, wdata:0, rdata:32'h1234_5678, mask:4'b1111, a:0, d:1, err:1};
    run_xfer(x, o);
    e = model(x, model_ldata); model_ldata = e.ldata;
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL load_error: got %s | expected %s", fmt(o), fmt(e)); end
    n_checks++;
    if (o.err !== 1'b1 || o.ld !== 1'b1 || o.ldata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL load_error_hold: got err=%b ld=%b ldata=%h, expected 1 1 DEADBEEF", o.err, o.ld, o.ldata);
    end
  endtask

  task automatic test_illegal_mask();
    xfer_t x; obs_t o, e;
    x = '{st:1, ld:0, addr:32'h0000_0500, wdata:32'h5555_5555, rdata:0, mask:4'b0101, a:0, d:0, err:0};
    run_xfer(x, o);
    e = model(x, model_ldata); model_ldata = e.ldata;
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL illegal_mask: got %s | expected %s", fmt(o), fmt(e)); end
    n_checks++;
    if (o.nseq !== 0 || o.done_cyc + 1 !== 2 || o.err !== 1'b1 || o.st !== 1'b1) begin
      n_fail++; $display("FAIL illegal_mask_timing: got nseq=%0d %0d cycles err=%b st=%b, expected 0 2 1 1", o.nseq, o.done_cyc + 1, o.err, o.st);
    end
  endtask

  task automatic test_watchdog();
    xfer_t x; obs_t o, e;
    x = '{st:0, ld:1, addr:32'h0000_0600, wdata:0, rdata:32'hCAFE_F00D, mask:4'b1111, a:0, d:10, err:0};
    run_xfer(x, o);
    e = model(x, model_ldata); model_ldata = e.ldata;
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL watchdog: got %s | expected %s", fmt(o), fmt(e)); end
    n_checks++;
    if (o.done_cyc !== 1 + TO || o.err !== 1'b1 || o.ldata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL watchdog_abort: got done@%0d err=%b ldata=%h, expected done@%0d 1 DEADBEEF", o.done_cyc, o.err, o.ldata, 1 + TO);
    end
  endtask

  task automatic test_load_store_together();
    xfer_t x; obs_t o, e;
    x = '{st:1, ld:1, addr:32'h0000_0704, wdata:32'hA5A5_5A5A, rdata:32'h0BAD_0BAD, mask:4'b1111, a:1, d:0, err:0};
    run_xfer(x, o);
    e = model(x, model_ldata); model_ldata = e.ldata;
    n_checks++;
    if (o !== e || o.hwrite !== 1'b1 || o.st !== 1'b1) begin
      n_fail++; $display("FAIL load_store_together: got %s | expected %s", fmt(o), fmt(e));
    end
  endtask

  task automatic test_reset_in_data();
    int pulses;
    @(negedge clk);
    dm_addr_i = 32'h0000_0800; dm_data_s_i = 32'h7777_8888; dm_data_select_i = 4'b1111;
    dm_store_i = 1'b1; dm_load_i = 1'b0; HREADY_I = 1'b1; HRESP_I = 1'b0;
    @(posedge clk); #1;
    dm_store_i = 1'b0;
    @(posedge clk); #1;
    HREADY_I = 1'b0;
    n_checks++;
    if ({HTRANS_O, HWRITE_O, HWDATA_O} !== {2'b00, 1'b1, 32'h7777_8888}) begin
      n_fail++; $display("FAIL rst_data_phase: got trans=%b wr=%b wd=%h, expected 00 1 77778888", HTRANS_O, HWRITE_O, HWDATA_O);
    end
    @(negedge clk); rst_i = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({HTRANS_O, dm_ready_o, dm_store_done_o, bus_err_o, HWDATA_O} !== {2'b00, 3'b100, 32'h0}) begin
      n_fail++; $display("FAIL rst_in_data: got trans=%b rdy=%b st=%b err=%b wd=%h, expected 00 1 0 0 0", HTRANS_O, dm_ready_o, dm_store_done_o, bus_err_o, HWDATA_O);
    end
    @(negedge clk); rst_i = 1'b0; HREADY_I = 1'b1;
    model_ldata = '0;
    pulses = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (dm_load_done_o || dm_store_done_o || bus_err_o || !dm_ready_o) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin n_fail++; $display("FAIL rst_no_done: got %0d busy/pulse cycles after reset, expected 0", pulses); end
  endtask

  task automatic test_random();
    xfer_t x; obs_t o, e;
    logic [3:0] legal_masks [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    for (int i = 0; i < 40; i++) begin
      int kind;
      kind    = $urandom_range(0, 2);
      x.st    = (kind != 0);
      x.ld    = (kind != 1);
      x.addr  = $urandom;
      x.wdata = $urandom;
      x.rdata = $urandom;
      x.mask  = ($urandom_range(0, 3) != 0) ? legal_masks[$urandom_range(0, 6)] : 4'($urandom);
      x.a     = $urandom_range(0, 2);
      x.d     = $urandom_range(0, 5);
      x.err   = ($urandom_range(0, 3) == 0);
      run_xfer(x, o);
      e = model(x, model_ldata); model_ldata = e.ldata;
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL random[%0d]: got %s | expected %s", i, fmt(o), fmt(e)); end
    end
  endtask

  initial begin
    rst_i = 1'b1; dm_addr_i = '0; dm_data_s_i = '0; dm_data_select_i = '0;
    dm_store_i = 1'b0; dm_load_i = 1'b0; HRDATA_I = '0; HREADY_I = 1'b1; HRESP_I = 1'b0;
    test_reset();
    test_word_load();
    test_byte_store();
    test_half_store_waits();
    test_load_error();
    test_illegal_mask();
    test_watchdog();
    test_load_store_together();
    test_reset_in_data();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/urv_dm_ahb_bridge.md
Name: urv_dm_ahb_bridge

Overview:
Converts the uRV CPU data-memory port (dm_* load/store strobes, byte-lane select, done/ready) into single AHB-Lite master transfers. Sits between the CPU data port and the AHB data slave (RAM or peripheral), alongside the existing AHB instruction-fetch port. Handles wait states, error responses, illegal lane masks and a stalled-slave watchdog.

Parameters:
HPROT_VAL, 4'b0011, constant driven on HPROT_O (non-cacheable privileged data access)
TIMEOUT_CYCLES, 255, max data-phase wait cycles before abort with error; 0 disables watchdog
CNT_W, 8, width of watchdog counter; must hold TIMEOUT_CYCLES

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous reset, active-high
dm_addr_i  in  32  byte address from CPU
dm_data_s_i  in  32  store data, lane-aligned
dm_data_select_i  in  4  byte-lane enables
dm_store_i  in  1  store request
dm_load_i  in  1  load request
dm_data_l_o  out  32  load data, full word as returned by HRDATA_I
dm_load_done_o  out  1  one-cycle pulse: load finished
dm_store_done_o  out  1  one-cycle pulse: store finished
dm_ready_o  out  1  bridge idle, request accepted this cycle
bus_err_o  out  1  one-cycle pulse coincident with the done pulse when the transfer failed
HADDR_O  out  32  AHB address
HTRANS_O  out  2  IDLE=00 / NONSEQ=10 only
HSIZE_O  out  3  000 byte, 001 half, 010 word
HWRITE_O  out  1  write transfer
HWDATA_O  out  32  write data (data phase)
HBURST_O  out  3  constant 000 (SINGLE)
HPROT_O  out  4  constant HPROT_VAL
HMASTLOCK_O  out  1  constant 0
HRDATA_I  in  32  read data
HREADY_I  in  1  transfer done / slave ready
HRESP_I  in  1  1 = ERROR

Behaviour:
- States: IDLE, ADDR, DATA, DONE.
- Reset (any state): next edge -> IDLE. HTRANS_O=00, HADDR_O=0, HSIZE_O=010, HWRITE_O=0, HWDATA_O=0, dm_data_l_o=0, all done/err pulses 0, dm_ready_o=1, watchdog=0. An in-flight transfer is abandoned with no done pulse.
- IDLE: dm_ready_o=1. On (dm_load_i|dm_store_i), latch request. store_i wins if both are high; that request is a store.
- Lane mask decode, HADDR_O[1:0]/HSIZE_O:
  - 0001/0010/0100/1000 -> offset 0/1/2/3, byte.
  - 0011/1100 -> offset 0/2, half.
  - 1111 -> offset 0, word.
  - HADDR_O[31:2]=dm_addr_i[31:2].
  - Load ignores the mask and is always a word at offset 0. The CPU extracts lanes.
- Illegal store mask (any other value, incl. 0000): no bus transfer. Go to DONE, pulse dm_store_done_o and bus_err_o.
- ADDR: HTRANS_O=NONSEQ. Address and control are held stable while HREADY_I=0. Edge with HREADY_I=1 -> DATA.
- DATA: HTRANS_O=IDLE. For a store, HWDATA_O=latched store data. Stays in DATA while HREADY_I=0, and the watchdog increments each such cycle. Edge with HREADY_I=1 -> DONE: capture HRDATA_I for a load, capture HRESP_I as error.
- HRESP_I=1 with HREADY_I=0 (first error cycle) just waits. Error is latched from the final cycle.
- Watchdog (TIMEOUT_CYCLES>0): counter reaches TIMEOUT_CYCLES in DATA -> DONE with error; the load data register is left unchanged.
- DONE: one cycle. Pulse dm_load_done_o or dm_store_done_o, and bus_err_o if an error was latched. dm_ready_o=0. Next -> IDLE.
- dm_ready_o=0 in ADDR/DATA/DONE. Requests there are ignored; the CPU holds them until ready.
- Zero-wait latency: request at edge N; NONSEQ during N..N+1; data phase N+1..N+2; done pulse in cycle N+2..N+3. Three cycles request to done, next request accepted at N+3.
- dm_data_l_o holds its last value until the next successful load. It is not updated on an errored load.

Test Plan:
- Word load, HREADY=1, addr 0x0000_0104, slave returns 0xDEADBEEF -> HADDR_O=0x104, HSIZE_O=010, HWRITE_O=0; dm_load_done_o pulses 3 cycles after request; dm_data_l_o=0xDEADBEEF; bus_err_o=0.
- Byte store, mask 0100, addr 0x200, data 0x00AB0000 -> HADDR_O=0x202, HSIZE_O=000, HWRITE_O=1, HWDATA_O=0x00AB0000 in data phase; dm_store_done_o pulses once.
- Half store, mask 1100, with 2 HREADY_I=0 cycles in the address phase and 3 in the data phase -> HADDR_O=0x..2 and HSIZE_O=001 stable throughout; done pulses 8 cycles after request; dm_ready_o=0 until then.
- Two-cycle ERROR response on load -> bus_err_o and dm_load_done_o pulse together; dm_data_l_o keeps its prior value.
- Illegal mask 0101 store -> HTRANS_O stays 00; dm_store_done_o and bus_err_o pulse 2 cycles after request. Separately, TIMEOUT_CYCLES=4 with HREADY_I held low -> error done after 4 wait cycles.
- rst_i asserted during DATA of a store -> next cycle HTRANS_O=00, dm_ready_o=1, no done pulse. Load and store requested together -> store transfer issued.
